busy_table_wr_arbiter: RTL

- Drives the busy table's single write port (wr_en, wr_addr, data).
- Merges one busy-set request per cycle from rename (newly allocated destination tag) with up to NUM_WB busy-clear requests per cycle from writeback.
- Clears are buffered in a small circular queue and drained one per cycle.
- A set for a tag cancels any still-queued clear for the same tag, so a stale clear never overwrites a re-allocation.

---
 rtl/busy_table_wr_arbiter_if.sv | 31 +++
 rtl/busy_table_wr_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/busy_table_wr_arbiter_if.sv
// Request/response bundle between rename/writeback and the busy-table write arbiter.
// The arbiter uses the slave modport; request producers use master.
interface busy_table_wr_arbiter_if #(
   parameter int unsigned PHY_RF_DEPTH = 128,
   parameter int unsigned NUM_WB       = 2,
   parameter int unsigned QUEUE_DEPTH  = 8
);
   localparam int unsigned AW = $clog2(PHY_RF_DEPTH);
   localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

   logic                 set_valid;
   logic [AW-1:0]        set_addr;
   logic                 set_ready;
   logic [NUM_WB-1:0]    clr_valid;
   logic [NUM_WB*AW-1:0] clr_addr;
   logic                 clr_ready;
   logic                 wr_en;
   logic [AW-1:0]        wr_addr;
   logic                 wr_data;
   logic [CW-1:0]        queue_count;

   modport master (
      output set_valid, set_addr, clr_valid, clr_addr,
      input  set_ready, clr_ready, wr_en, wr_addr, wr_data, queue_count
   );

   modport slave (
      input  set_valid, set_addr, clr_valid, clr_addr,
      output set_ready, clr_ready, wr_en, wr_addr, wr_data, queue_count
   );
endinterface

// File: rtl/busy_table_wr_arbiter.sv
// Arbitrates the busy table's single write port between rename sets and a queue
// of writeback clears; an accepted set cancels any queued clear of the same tag.
module busy_table_wr_arbiter #(
   parameter int unsigned PHY_RF_DEPTH = 128,
   parameter int unsigned NUM_WB       = 2,
   parameter int unsigned QUEUE_DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   busy_table_wr_arbiter_if.slave   bus
);
   localparam int unsigned AW = $clog2(PHY_RF_DEPTH);
   localparam int unsigned PW = $clog2(QUEUE_DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [CW-1:0]          head;
   logic [CW-1:0]          tail;
   logic [CW-1:0]          tail_n;
   logic [CW-1:0]          count;
   logic [QUEUE_DEPTH-1:0] q_valid;
   logic [QUEUE_DEPTH-1:0] q_valid_n;
   logic [AW-1:0]          q_addr   [QUEUE_DEPTH];
   logic [AW-1:0]          q_addr_n [QUEUE_DEPTH];
   logic                   set_acc;
   logic                   pop;
   logic [PW-1:0]          head_idx;

   // Pointers carry one extra wrap bit so a full queue is distinct from empty.
   assign count           = tail - head;
   assign bus.queue_count = count;
   assign bus.clr_ready   = (count <= CW'(QUEUE_DEPTH - NUM_WB));
   assign bus.set_ready   = (count <  CW'(QUEUE_DEPTH - NUM_WB));
   assign set_acc         = bus.set_valid && bus.set_ready;
   assign pop             = !set_acc && (count != '0);
   assign head_idx        = head[PW-1:0];

   // Cancel queued clears hit by an accepted set, then compact-push incoming clears.
   always_comb begin
      q_valid_n = q_valid;
      q_addr_n  = q_addr;
      tail_n    = tail;
      if (set_acc) begin
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            if (q_addr[i] == bus.set_addr) q_valid_n[i] = 1'b0;
         end
      end
      if (bus.clr_ready) begin
         for (int p = 0; p < int'(NUM_WB); p++) begin
            if (bus.clr_valid[p]) begin
               q_valid_n[tail_n[PW-1:0]] = !(set_acc && (bus.clr_addr[p*AW +: AW] == bus.set_addr));
               q_addr_n[tail_n[PW-1:0]]  = bus.clr_addr[p*AW +: AW];
               tail_n                    = tail_n + CW'(1);
            end
         end
      end
   end

   // Queue control and the registered write port; sets take priority over pops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head        <= '0;
         tail        <= '0;
         q_valid     <= '0;
         bus.wr_en   <= 1'b0;
         bus.wr_addr <= '0;
         bus.wr_data <= 1'b0;
      end else begin
         tail    <= tail_n;
         q_valid <= q_valid_n;
         if (set_acc) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= bus.set_addr;
            bus.wr_data <= 1'b1;
         end else if (pop) begin
            head        <= head + CW'(1);
            bus.wr_en   <= q_valid[head_idx];
            bus.wr_addr <= q_addr[head_idx];
            bus.wr_data <= 1'b0;
         end else begin
            bus.wr_en   <= 1'b0;
         end
      end
   end

   // Entry addresses are qualified by q_valid and need no reset.
   always_ff @(posedge clk) begin
      q_addr <= q_addr_n;
   end
endmodule
